// File: rtl/rename_regfile_if.sv
// rename_regfile_if: dispatch, commit, flush and operand-packet signals of the rename register file
// master drives in_* (decode/ROB side) and observes out_*; slave is the register file itself.
interface rename_regfile_if #(
    parameter int GPR_COUNT = 32,
    parameter int GPR_WIDTH = 64,
    parameter int ROB_DEPTH = 16,
    parameter int IMM_WIDTH = 64
);
    localparam int RIDX_W    = $clog2(GPR_COUNT);
    localparam int ROB_IDX_W = $clog2(ROB_DEPTH);
    logic                 in_d_valid;
    logic [RIDX_W-1:0]    in_d_src1, in_d_src2, in_d_dst;
    logic                 in_d_writes_dst, in_d_use_imm;
    logic [IMM_WIDTH-1:0] in_d_imm;
    logic                 in_d_set_nzcv, in_d_uses_nzcv;
    logic [ROB_IDX_W-1:0] in_rob_alloc_idx;
    logic                 in_c_valid;
    logic [RIDX_W-1:0]    in_c_reg;
    logic                 in_c_writes_dst;
    logic [GPR_WIDTH-1:0] in_c_value;
    logic [ROB_IDX_W-1:0] in_c_rob_idx;
    logic                 in_c_set_nzcv;
    logic [3:0]           in_c_nzcv;
    logic                 in_flush;
    logic                 out_valid;
    logic                 out_src1_ready, out_src2_ready, out_nzcv_ready;
    logic [GPR_WIDTH-1:0] out_src1_value, out_src2_value;
    logic [ROB_IDX_W-1:0] out_src1_tag, out_src2_tag, out_nzcv_tag;
    logic [3:0]           out_nzcv;
    logic [RIDX_W-1:0]    out_dst;
    logic                 out_writes_dst, out_set_nzcv, out_uses_nzcv;
    logic [ROB_IDX_W-1:0] out_rob_idx;
    modport master (
        output in_d_valid, in_d_src1, in_d_src2, in_d_dst, in_d_writes_dst, in_d_use_imm, in_d_imm,
               in_d_set_nzcv, in_d_uses_nzcv, in_rob_alloc_idx, in_c_valid, in_c_reg, in_c_writes_dst,
               in_c_value, in_c_rob_idx, in_c_set_nzcv, in_c_nzcv, in_flush,
        input  out_valid, out_src1_ready, out_src2_ready, out_nzcv_ready, out_src1_value, out_src2_value,
               out_src1_tag, out_src2_tag, out_nzcv_tag, out_nzcv, out_dst, out_writes_dst, out_set_nzcv,
               out_uses_nzcv, out_rob_idx
    );
    modport slave (
        input  in_d_valid, in_d_src1, in_d_src2, in_d_dst, in_d_writes_dst, in_d_use_imm, in_d_imm,
               in_d_set_nzcv, in_d_uses_nzcv, in_rob_alloc_idx, in_c_valid, in_c_reg, in_c_writes_dst,
               in_c_value, in_c_rob_idx, in_c_set_nzcv, in_c_nzcv, in_flush,
        output out_valid, out_src1_ready, out_src2_ready, out_nzcv_ready, out_src1_value, out_src2_value,
               out_src1_tag, out_src2_tag, out_nzcv_tag, out_nzcv, out_dst, out_writes_dst, out_set_nzcv,
               out_uses_nzcv, out_rob_idx
    );
endinterface

// File: rtl/rename_regfile.sv
// rename_regfile: architectural GPR/NZCV file with ROB-tag rename table and registered operand lookup
// Ports: in_clk clock, in_rst async active-high reset, bus (slave) carrying dispatch, commit, flush
// inputs and the registered operand packet (value or producer tag per source, plus passthroughs).
module rename_regfile #(
    parameter int GPR_COUNT = 32,
    parameter int GPR_WIDTH = 64,
    parameter int ROB_DEPTH = 16,
    parameter int ZERO_REG  = 31,
    parameter int IMM_WIDTH = 64
) (
    input logic             in_clk,
    input logic             in_rst,
    rename_regfile_if.slave bus
);
    localparam int RIDX_W    = $clog2(GPR_COUNT);
    localparam int ROB_IDX_W = $clog2(ROB_DEPTH);
    localparam logic [RIDX_W-1:0] ZIDX = RIDX_W'(ZERO_REG);
    typedef struct packed {
        logic                 rdy;
        logic [GPR_WIDTH-1:0] val;
        logic [ROB_IDX_W-1:0] tag;
    } opnd_t;
    logic [GPR_WIDTH-1:0] value_q [GPR_COUNT];
    logic [GPR_WIDTH-1:0] value_d [GPR_COUNT];
    logic [ROB_IDX_W-1:0] tag_q   [GPR_COUNT];
    logic [ROB_IDX_W-1:0] tag_d   [GPR_COUNT];
    logic [GPR_COUNT-1:0] busy_q, busy_d;
    logic [3:0]           nzcv_q, nzcv_d;
    logic                 nzcv_busy_q, nzcv_busy_d;
    logic [ROB_IDX_W-1:0] nzcv_tag_q, nzcv_tag_d;
    logic [RIDX_W-1:0]    sidx [2];
    opnd_t                opnd [2];
    opnd_t                src1_q, src2_q;
    logic                 nz_rdy, nz_rdy_q;
    logic [3:0]           nz_val, nz_val_q;
    logic [ROB_IDX_W-1:0] nz_tag_q, rob_q;
    logic [RIDX_W-1:0]    dst_q;
    logic                 valid_q, wd_q, sn_q, un_q;
    logic                 c_gpr, c_nz, accept;
    assign c_gpr  = bus.in_c_valid && bus.in_c_writes_dst;
    assign c_nz   = bus.in_c_valid && bus.in_c_set_nzcv;
    assign accept = bus.in_d_valid && !bus.in_flush;
    // Lookup reads pre-rename state, so src == dst naturally returns the previous producer.
    always_comb begin
        sidx[0] = bus.in_d_src1;
        sidx[1] = bus.in_d_src2;
        for (int i = 0; i < 2; i++) begin
            opnd[i].tag = tag_q[sidx[i]];
            opnd[i].rdy = sidx[i] == ZIDX || !busy_q[sidx[i]] ||
                          (c_gpr && bus.in_c_reg == sidx[i] && bus.in_c_rob_idx == tag_q[sidx[i]]);
            opnd[i].val = sidx[i] == ZIDX ? '0 : busy_q[sidx[i]] ? bus.in_c_value : value_q[sidx[i]];
        end
        if (bus.in_d_use_imm && sidx[1] != ZIDX) begin
            opnd[1].rdy = 1'b1;
            opnd[1].val = GPR_WIDTH'(bus.in_d_imm);
        end
        nz_rdy = !nzcv_busy_q || (c_nz && bus.in_c_rob_idx == nzcv_tag_q);
        nz_val = nzcv_busy_q ? bus.in_c_nzcv : nzcv_q;
    end
    // Commit first, then flush or rename on top, so a same-cycle rename overrides the commit clear.
    always_comb begin
        value_d     = value_q;
        tag_d       = tag_q;
        busy_d      = busy_q;
        nzcv_d      = nzcv_q;
        nzcv_busy_d = nzcv_busy_q;
        nzcv_tag_d  = nzcv_tag_q;
        if (c_gpr && bus.in_c_reg != ZIDX) begin
            value_d[bus.in_c_reg] = bus.in_c_value;
            if (busy_q[bus.in_c_reg] && tag_q[bus.in_c_reg] == bus.in_c_rob_idx) busy_d[bus.in_c_reg] = 1'b0;
        end
        if (c_nz) begin
            nzcv_d = bus.in_c_nzcv;
            if (nzcv_busy_q && nzcv_tag_q == bus.in_c_rob_idx) nzcv_busy_d = 1'b0;
        end
        if (bus.in_flush) begin
            busy_d      = '0;
            nzcv_busy_d = 1'b0;
        end else if (bus.in_d_valid) begin
            if (bus.in_d_writes_dst && bus.in_d_dst != ZIDX) begin
                busy_d[bus.in_d_dst] = 1'b1;
                tag_d[bus.in_d_dst]  = bus.in_rob_alloc_idx;
            end
            if (bus.in_d_set_nzcv) begin
                nzcv_busy_d = 1'b1;
                nzcv_tag_d  = bus.in_rob_alloc_idx;
            end
        end
    end
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            for (int i = 0; i < GPR_COUNT; i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= '0;
            end
            busy_q      <= '0;
            nzcv_q      <= '0;
            nzcv_busy_q <= 1'b0;
            nzcv_tag_q  <= '0;
            valid_q     <= 1'b0;
            src1_q      <= '0;
            src2_q      <= '0;
            nz_rdy_q    <= 1'b0;
            nz_val_q    <= '0;
            nz_tag_q    <= '0;
            dst_q       <= '0;
            wd_q        <= 1'b0;
            sn_q        <= 1'b0;
            un_q        <= 1'b0;
            rob_q       <= '0;
        end else begin
            value_q     <= value_d;
            tag_q       <= tag_d;
            busy_q      <= busy_d;
            nzcv_q      <= nzcv_d;
            nzcv_busy_q <= nzcv_busy_d;
            nzcv_tag_q  <= nzcv_tag_d;
            valid_q     <= accept;
            if (accept) begin
                src1_q   <= opnd[0];
                src2_q   <= opnd[1];
                nz_rdy_q <= nz_rdy;
                nz_val_q <= nz_val;
                nz_tag_q <= nzcv_tag_q;
                dst_q    <= bus.in_d_dst;
                wd_q     <= bus.in_d_writes_dst;
                sn_q     <= bus.in_d_set_nzcv;
                un_q     <= bus.in_d_uses_nzcv;
                rob_q    <= bus.in_rob_alloc_idx;
            end
        end
    end
    assign bus.out_valid      = valid_q;
    assign bus.out_src1_ready = src1_q.rdy;
    assign bus.out_src1_value = src1_q.val;
    assign bus.out_src1_tag   = src1_q.tag;
    assign bus.out_src2_ready = src2_q.rdy;
    assign bus.out_src2_value = src2_q.val;
    assign bus.out_src2_tag   = src2_q.tag;
    assign bus.out_nzcv_ready = nz_rdy_q;
    assign bus.out_nzcv       = nz_val_q;
    assign bus.out_nzcv_tag   = nz_tag_q;
    assign bus.out_dst        = dst_q;
    assign bus.out_writes_dst = wd_q;
    assign bus.out_set_nzcv   = sn_q;
    assign bus.out_uses_nzcv  = un_q;
    assign bus.out_rob_idx    = rob_q;
endmodule
